// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch sequencer: state encoding, branch-condition codes, sizes.
// Latency: none (definitions only); no backpressure.
package fetch_unit_pkg;

  localparam int PC_W_DEFAULT = 10;
  localparam int LUT_DEPTH    = 4;
  localparam int LUT_IDX_W    = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam logic [1:0] kBrAlways = 2'b00;
  localparam logic [1:0] kBrZ      = 2'b01;
  localparam logic [1:0] kBrNZ     = 2'b10;
  localparam logic [1:0] kBrN      = 2'b11;

  function automatic logic cond_met(input logic [1:0] cond, input logic z, input logic n);
    logic met;
    met = 1'b0;
    case (cond)
      kBrAlways: met = 1'b1;
      kBrZ:      met = z;
      kBrNZ:     met = ~z;
      kBrN:      met = n;
      default:   met = 1'b0;
    endcase
    return met;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Decoder/harness <-> fetch sequencer bundle; master drives control, slave returns PC/status.
// Latency: wires only; no backpressure.
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT
) ();

  logic                 Start;
  logic [PC_W-1:0]      StartAddr;
  logic                 Ack;
  logic                 ConditionalJump;
  logic                 BranchAbsOrRel;
  logic [1:0]           BranchConditions;
  logic [LUT_IDX_W-1:0] TargIdx;
  logic                 FlagWrEn;
  logic                 ZeroIn;
  logic                 NegIn;
  logic                 LutWrEn;
  logic                 LutWrSel;
  logic [LUT_IDX_W-1:0] LutWrIdx;
  logic [PC_W-1:0]      LutWrData;
  logic [PC_W-1:0]      ProgCtr;
  logic                 Running;
  logic                 Done;
  logic                 Taken;

  modport master (
    output Start, StartAddr, Ack, ConditionalJump, BranchAbsOrRel, BranchConditions,
           TargIdx, FlagWrEn, ZeroIn, NegIn, LutWrEn, LutWrSel, LutWrIdx, LutWrData,
    input  ProgCtr, Running, Done, Taken
  );

  modport slave (
    input  Start, StartAddr, Ack, ConditionalJump, BranchAbsOrRel, BranchConditions,
           TargIdx, FlagWrEn, ZeroIn, NegIn, LutWrEn, LutWrSel, LutWrIdx, LutWrData,
    output ProgCtr, Running, Done, Taken
  );

endinterface

// File: rtl/fetch_unit_branch_lut.sv
// Absolute and relative branch-target tables: one write port, combinational read of both.
// Latency: writes visible the cycle after; reads are same-cycle (old value on collision); no backpressure.
module branch_lut
  import fetch_unit_pkg::*;
#(
  parameter int W     = PC_W_DEFAULT,
  parameter int DEPTH = LUT_DEPTH
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 wr_en,
  input  logic                 wr_sel,
  input  logic [LUT_IDX_W-1:0] wr_idx,
  input  logic [W-1:0]         wr_data,
  input  logic [LUT_IDX_W-1:0] rd_idx,
  output logic [W-1:0]         abs_data,
  output logic [W-1:0]         rel_data
);

  logic [W-1:0] abs_tab [DEPTH];
  logic [W-1:0] rel_tab [DEPTH];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        abs_tab[i] <= '0;
        rel_tab[i] <= '0;
      end
    end else if (wr_en) begin
      if (wr_sel) rel_tab[wr_idx] <= wr_data;
      else        abs_tab[wr_idx] <= wr_data;
    end
  end

  assign abs_data = abs_tab[rd_idx];
  assign rel_data = rel_tab[rd_idx];

endmodule

// File: rtl/fetch_unit.sv
// Program counter / fetch sequencer with Z/N condition flags and IDLE/RUN/HALT harness handshake.
// Latency: next address registered at the edge ending the current cycle; never stalls, no backpressure.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT
) (
  input  logic         Clk,
  input  logic         Reset,
  fetch_unit_if.slave  bus
);

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  fetch_state_t    state;
  logic [PC_W-1:0] pc;
  logic            running;
  logic            done;
  logic            taken;
  logic            z_flag;
  logic            n_flag;

  logic [PC_W-1:0] abs_data;
  logic [PC_W-1:0] rel_data;
  logic [PC_W-1:0] target;
  logic            branch_go;

  branch_lut #(
    .W     (PC_W),
    .DEPTH (LUT_DEPTH)
  ) u_lut (
    .Clk      (Clk),
    .Reset    (Reset),
    .wr_en    (bus.LutWrEn),
    .wr_sel   (bus.LutWrSel),
    .wr_idx   (bus.LutWrIdx),
    .wr_data  (bus.LutWrData),
    .rd_idx   (bus.TargIdx),
    .abs_data (abs_data),
    .rel_data (rel_data)
  );

  // Condition uses flags as they stand at the start of the cycle; modular add handles negative offsets.
  assign branch_go = bus.ConditionalJump && cond_met(bus.BranchConditions, z_flag, n_flag);
  assign target    = bus.BranchAbsOrRel ? (pc + rel_data) : abs_data;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      pc      <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      taken   <= 1'b0;
      z_flag  <= 1'b0;
      n_flag  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          taken <= 1'b0;
          if (bus.Start) begin
            pc      <= bus.StartAddr;
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (bus.Ack) begin
            state   <= HALT;
            running <= 1'b0;
            done    <= 1'b1;
            taken   <= 1'b0;
          end else begin
            if (bus.FlagWrEn) begin
              z_flag <= bus.ZeroIn;
              n_flag <= bus.NegIn;
            end
            if (branch_go) begin
              pc    <= target;
              taken <= 1'b1;
            end else begin
              pc    <= pc + PC_ONE;
              taken <= 1'b0;
            end
          end
        end
        HALT: begin
          taken <= 1'b0;
          if (bus.Start) begin
            pc      <= bus.StartAddr;
            state   <= RUN;
            running <= 1'b1;
            done    <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
          done    <= 1'b0;
          taken   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ProgCtr = pc;
  assign bus.Running = running;
  assign bus.Done    = done;
  assign bus.Taken   = taken;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed-vector bench for fetch_unit with hand-computed expected addresses and status.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int PC_W = 10;

  logic Clk;
  logic Reset;
  int   n_vec;
  int   n_err;

  fetch_unit_if #(.PC_W(PC_W)) bus ();

  fetch_unit #(.PC_W(PC_W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_pc(input string tag, input int exp);
    check(tag, 32'(bus.ProgCtr), exp);
  endtask

  task automatic chk_st(input string tag, input int run, input int dn, input int tk);
    check({tag, ".run"}, 32'(bus.Running), run);
    check({tag, ".done"}, 32'(bus.Done), dn);
    check({tag, ".taken"}, 32'(bus.Taken), tk);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_ins();
    bus.Start            = 1'b0;
    bus.StartAddr        = '0;
    bus.Ack              = 1'b0;
    bus.ConditionalJump  = 1'b0;
    bus.BranchAbsOrRel   = 1'b0;
    bus.BranchConditions = kBrAlways;
    bus.TargIdx          = '0;
    bus.FlagWrEn         = 1'b0;
    bus.ZeroIn           = 1'b0;
    bus.NegIn            = 1'b0;
    bus.LutWrEn          = 1'b0;
    bus.LutWrSel         = 1'b0;
    bus.LutWrIdx         = '0;
    bus.LutWrData        = '0;
  endtask

  task automatic lut(input logic sel, input logic [1:0] idx, input logic [PC_W-1:0] data);
    bus.LutWrEn   = 1'b1;
    bus.LutWrSel  = sel;
    bus.LutWrIdx  = idx;
    bus.LutWrData = data;
  endtask

  task automatic br(input logic rel, input logic [1:0] cond, input logic [1:0] idx);
    bus.ConditionalJump  = 1'b1;
    bus.BranchAbsOrRel   = rel;
    bus.BranchConditions = cond;
    bus.TargIdx          = idx;
  endtask

  task automatic flags(input logic z, input logic n);
    bus.FlagWrEn = 1'b1;
    bus.ZeroIn   = z;
    bus.NegIn    = n;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    Reset = 1'b0;
    idle_ins();
    #12;
    chk_pc("rst.pc", 0);
    chk_st("rst", 0, 0, 0);
    #8 Reset = 1'b1;

    // Start and sequential fetch
    idle_ins(); bus.Start = 1'b1; bus.StartAddr = 10'd10; tick();
    chk_pc("start.pc", 10); chk_st("start", 1, 0, 0);
    idle_ins(); tick(); chk_pc("seq11", 11);
    tick(); chk_pc("seq12", 12);
    tick(); chk_pc("seq13", 13);

    // Table fill while running
    idle_ins(); lut(1'b0, 2'd2, 10'd100);   tick(); chk_pc("wr.a2", 14);
    idle_ins(); lut(1'b1, 2'd1, 10'h3F8);   tick(); chk_pc("wr.r1", 15);
    idle_ins(); lut(1'b0, 2'd0, 10'd5);     tick(); chk_pc("wr.a0", 16);
    idle_ins(); tick(); tick(); tick(); tick(); chk_pc("at20", 20);

    // Absolute unconditional branch
    br(1'b0, kBrAlways, 2'd2); tick();
    chk_pc("abs.pc", 100); chk_st("abs", 1, 0, 1);
    idle_ins(); tick(); chk_pc("abs.next", 101); check("abs.next.taken", 32'(bus.Taken), 0);

    // Conditional relative branch on Z
    br(1'b0, kBrAlways, 2'd0); tick(); chk_pc("to5a", 5);
    idle_ins(); flags(1'b1, 1'b0); tick(); chk_pc("z.set", 6);
    idle_ins(); br(1'b1, kBrZ, 2'd1); tick();
    chk_pc("rel.z", 1022); check("rel.z.taken", 32'(bus.Taken), 1);
    idle_ins(); br(1'b0, kBrAlways, 2'd0); tick(); chk_pc("to5b", 5);
    idle_ins(); tick(); chk_pc("at6", 6);
    br(1'b1, kBrNZ, 2'd1); tick();
    chk_pc("rel.nz", 7); check("rel.nz.taken", 32'(bus.Taken), 0);

    // Same-cycle flag write does not affect this cycle's condition
    idle_ins(); flags(1'b0, 1'b0); tick(); chk_pc("z.clr", 8);
    idle_ins(); flags(1'b1, 1'b0); br(1'b1, kBrZ, 2'd1); tick();
    chk_pc("samecyc", 9); check("samecyc.taken", 32'(bus.Taken), 0);
    idle_ins(); br(1'b1, kBrZ, 2'd1); tick();
    chk_pc("z.next", 1); check("z.next.taken", 32'(bus.Taken), 1);
    idle_ins(); flags(1'b0, 1'b1); tick(); chk_pc("n.set", 2);
    idle_ins(); br(1'b0, kBrN, 2'd2); tick(); chk_pc("br.n", 100);

    // Wrap, same-cycle table collision, halt and restart
    idle_ins(); lut(1'b0, 2'd3, 10'd1023); tick(); chk_pc("wr.a3", 101);
    idle_ins(); br(1'b0, kBrAlways, 2'd3); tick(); chk_pc("to1023", 1023);
    idle_ins(); tick(); chk_pc("wrap", 0);
    idle_ins(); lut(1'b0, 2'd1, 10'd40); br(1'b0, kBrAlways, 2'd1); tick();
    chk_pc("wr.rd.old", 0);
    idle_ins(); br(1'b0, kBrAlways, 2'd1); tick(); chk_pc("to40", 40);
    idle_ins(); bus.Ack = 1'b1; flags(1'b1, 1'b0); tick();
    chk_pc("halt.pc", 40); chk_st("halt", 0, 1, 0);
    idle_ins(); tick(); chk_pc("halt.hold", 40); check("halt.hold.done", 32'(bus.Done), 1);
    bus.Start = 1'b1; bus.StartAddr = 10'd0; tick();
    chk_pc("restart.pc", 0); chk_st("restart", 1, 0, 0);
    idle_ins(); br(1'b0, kBrZ, 2'd2); tick(); chk_pc("ack.flag.ign", 1);
    idle_ins(); bus.Start = 1'b1; bus.StartAddr = 10'd500; tick(); chk_pc("start.ign", 2);

    // Async reset mid-run
    idle_ins(); lut(1'b0, 2'd1, 10'd77); flags(1'b1, 1'b0); tick(); chk_pc("wr.a1", 3);
    idle_ins(); br(1'b0, kBrZ, 2'd1); tick(); chk_pc("to77", 77);
    idle_ins();
    #2 Reset = 1'b0;
    #1 chk_pc("arst.pc", 0); chk_st("arst", 0, 0, 0);
    #1 Reset = 1'b1;
    tick(); chk_pc("idle.hold", 0); check("idle.hold.run", 32'(bus.Running), 0);
    bus.Start = 1'b1; bus.StartAddr = 10'd50; tick(); chk_pc("rst.start", 50);
    idle_ins(); br(1'b0, kBrAlways, 2'd1); tick(); chk_pc("abs.clr", 0);
    idle_ins(); br(1'b0, kBrZ, 2'd2); tick(); chk_pc("z.clr.rst", 1);
    idle_ins(); br(1'b1, kBrAlways, 2'd1); tick(); chk_pc("rel.clr", 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
